// File: rtl/cpuid_csr_window_if.sv
// cpuid_csr_window_if
//   CSR request/response channel between the core CSR unit (master) and the
//   CPUID CSR window (slave).
//   Request : req_valid/req_ready handshake carrying req_write, req_addr, req_wdata.
//   Response: rsp_valid/rsp_ready handshake carrying rsp_rdata, rsp_err.
interface cpuid_csr_window_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/cpuid_csr_window.sv
// cpuid_csr_window
//   CSR-window front-end for the Z480 CPUID leaf model. Holds the LEAF and
//   SUBLEAF selectors that drive the combinational CPUID block and, on a
//   software "go", waits SETTLE_CYCLES and captures the four result lanes
//   into read-only DATA registers.
//
//   Window map (offset = req_addr[2:0]):
//     0 LEAF (rw, 32b)   1 SUBLEAF (rw, 32b)   2 CTRL/STATUS (w: bit0 go,
//     r: {done, busy})   3..6 DATA0..DATA3 (ro)   7 reserved (error)
//
// Ports:
//   clk            clock, all state on rising edge
//   rst_n          synchronous active-low reset
//   bus            CSR request/response channel (slave side)
//   cpuid_leaf     leaf selector to the CPUID block
//   cpuid_subleaf  subleaf selector to the CPUID block
//   cpuid_data0..3 result lanes from the CPUID block
//   busy           query in progress
module cpuid_csr_window #(
  parameter int              ADDR_W        = 12,
  parameter logic [ADDR_W-1:0] CSR_BASE    = 12'h0C0,
  parameter int              SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cpuid_csr_window_if.slave      bus,
  output logic [31:0]            cpuid_leaf,
  output logic [31:0]            cpuid_subleaf,
  input  logic [63:0]            cpuid_data0,
  input  logic [63:0]            cpuid_data1,
  input  logic [63:0]            cpuid_data2,
  input  logic [63:0]            cpuid_data3,
  output logic                   busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  if (CSR_BASE[2:0] != 3'b000) begin : g_bad_base
    $error("cpuid_csr_window: CSR_BASE must be 8-aligned");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("cpuid_csr_window: SETTLE_CYCLES must be 1..15");
  end

  logic [1:0]  state_reg;
  logic [3:0]  settle_cnt_reg;
  logic [31:0] leaf_reg;
  logic [31:0] subleaf_reg;
  logic        done_reg;
  logic [63:0] data_reg [4];
  logic [63:0] lane_in  [4];
  logic        rsp_valid_reg;
  logic [63:0] rsp_rdata_reg;
  logic        rsp_err_reg;

  logic        hit;
  logic [2:0]  offset;
  logic        accept;
  logic [63:0] rdata_next;
  logic        err_next;
  logic        wr_leaf;
  logic        wr_subleaf;
  logic        go;

  // Only the low 32 bits of write data carry register content.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^bus.req_wdata[63:32];

  assign busy          = (state_reg != ST_IDLE);
  assign cpuid_leaf    = leaf_reg;
  assign cpuid_subleaf = subleaf_reg;

  // New request accepted only when idle and the response slot is free or
  // draining this very cycle, which allows back-to-back accepts.
  assign bus.req_ready = !busy && (!rsp_valid_reg || bus.rsp_ready);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;

  assign hit    = (bus.req_addr[ADDR_W-1:3] == CSR_BASE[ADDR_W-1:3]);
  assign offset = bus.req_addr[2:0];
  assign accept = bus.req_valid && bus.req_ready;

  assign lane_in[0] = cpuid_data0;
  assign lane_in[1] = cpuid_data1;
  assign lane_in[2] = cpuid_data2;
  assign lane_in[3] = cpuid_data3;

  // Address decode; read data is sampled here, at acceptance.
  always_comb begin
    rdata_next = '0;
    err_next   = 1'b0;
    wr_leaf    = 1'b0;
    wr_subleaf = 1'b0;
    go         = 1'b0;
    if (!hit) begin
      err_next = 1'b1;
    end else begin
      case (offset)
        3'd0: begin
          if (bus.req_write) wr_leaf = 1'b1;
          else               rdata_next = {32'b0, leaf_reg};
        end
        3'd1: begin
          if (bus.req_write) wr_subleaf = 1'b1;
          else               rdata_next = {32'b0, subleaf_reg};
        end
        3'd2: begin
          if (bus.req_write) go = bus.req_wdata[0];
          else               rdata_next = {62'b0, done_reg, busy};
        end
        3'd3, 3'd4, 3'd5, 3'd6: begin
          if (bus.req_write) err_next = 1'b1;
          else               rdata_next = data_reg[offset - 3'd3];
        end
        default: err_next = 1'b1;
      endcase
    end
  end

  // Response register: loads on accept, otherwise clears when consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else if (accept) begin
      rsp_valid_reg <= 1'b1;
      rsp_rdata_reg <= rdata_next;
      rsp_err_reg   <= err_next;
    end else if (bus.rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  // Selectors, done flag and query FSM.
  // Busy spans exactly SETTLE_CYCLES cycles: SETTLE_CYCLES-1 in SETTLE
  // plus the single CAPTURE cycle, so SETTLE exits when the count is 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      settle_cnt_reg <= '0;
      leaf_reg       <= '0;
      subleaf_reg    <= '0;
      done_reg       <= 1'b0;
    end else begin
      if (accept && wr_leaf) begin
        leaf_reg <= bus.req_wdata[31:0];
        done_reg <= 1'b0;
      end
      if (accept && wr_subleaf) begin
        subleaf_reg <= bus.req_wdata[31:0];
        done_reg    <= 1'b0;
      end
      case (state_reg)
        ST_IDLE: begin
          if (accept && go) begin
            settle_cnt_reg <= SETTLE_LOAD;
            done_reg       <= 1'b0;
            state_reg      <= (SETTLE_LOAD == 4'd0) ? ST_CAPTURE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          settle_cnt_reg <= settle_cnt_reg - 4'd1;
          if (settle_cnt_reg == 4'd1) state_reg <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Result lanes are sampled at the end of the CAPTURE cycle.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_reg[gi] <= '0;
      end else if (state_reg == ST_CAPTURE) begin
        data_reg[gi] <= lane_in[gi];
      end
    end
  end

endmodule

// File: tb/tb_cpuid_csr_window.sv
// tb_cpuid_csr_window
//   Directed bench for cpuid_csr_window. Two instances share the clock:
//   index 0 uses SETTLE_CYCLES = 1, index 1 uses SETTLE_CYCLES = 4.
//   A small CPUID lane model stands in for the downstream leaf block.
module tb_cpuid_csr_window;

  localparam logic [11:0] BASE = 12'h0C0;
  localparam logic [31:0] LEAF_VENDOR = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst_n_d     [2];
  logic        req_valid_d [2];
  logic        req_write_d [2];
  logic [11:0] req_addr_d  [2];
  logic [63:0] req_wdata_d [2];
  logic        rsp_ready_d [2];

  logic        req_ready_o [2];
  logic        rsp_valid_o [2];
  logic [63:0] rsp_rdata_o [2];
  logic        rsp_err_o   [2];
  logic [31:0] leaf_o      [2];
  logic [31:0] sub_o       [2];
  logic        busy_o      [2];

  logic [63:0] cd0 [4];
  logic [63:0] cd1 [4];

  // CPUID block model: vendor leaf returns "CARBON-Z480 " lanes.
  function automatic logic [63:0] lane_model(input int k, input logic [31:0] leaf,
                                             input logic [31:0] sub);
    if (leaf == LEAF_VENDOR) begin
      case (k)
        0: return 64'h0000_0000_0000_0010;
        1: return 64'h0000_0000_4252_4143;
        2: return 64'h0000_0000_5A2D_4E4F;
        default: return 64'h0000_0000_2030_3834;
      endcase
    end
    return {leaf + 32'(k) * 32'h0101_0000, sub ^ 32'(k + 1)};
  endfunction

  cpuid_csr_window_if #(.ADDR_W(12)) bus0 ();
  cpuid_csr_window_if #(.ADDR_W(12)) bus1 ();

  assign bus0.req_valid = req_valid_d[0];
  assign bus0.req_write = req_write_d[0];
  assign bus0.req_addr  = req_addr_d[0];
  assign bus0.req_wdata = req_wdata_d[0];
  assign bus0.rsp_ready = rsp_ready_d[0];
  assign req_ready_o[0] = bus0.req_ready;
  assign rsp_valid_o[0] = bus0.rsp_valid;
  assign rsp_rdata_o[0] = bus0.rsp_rdata;
  assign rsp_err_o[0]   = bus0.rsp_err;

  assign bus1.req_valid = req_valid_d[1];
  assign bus1.req_write = req_write_d[1];
  assign bus1.req_addr  = req_addr_d[1];
  assign bus1.req_wdata = req_wdata_d[1];
  assign bus1.rsp_ready = rsp_ready_d[1];
  assign req_ready_o[1] = bus1.req_ready;
  assign rsp_valid_o[1] = bus1.rsp_valid;
  assign rsp_rdata_o[1] = bus1.rsp_rdata;
  assign rsp_err_o[1]   = bus1.rsp_err;

  for (genvar gi = 0; gi < 4; gi++) begin : g_model
    assign cd0[gi] = lane_model(gi, leaf_o[0], sub_o[0]);
    assign cd1[gi] = lane_model(gi, leaf_o[1], sub_o[1]);
  end

  cpuid_csr_window #(.ADDR_W(12), .CSR_BASE(BASE), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n_d[0]), .bus(bus0),
    .cpuid_leaf(leaf_o[0]), .cpuid_subleaf(sub_o[0]),
    .cpuid_data0(cd0[0]), .cpuid_data1(cd0[1]), .cpuid_data2(cd0[2]), .cpuid_data3(cd0[3]),
    .busy(busy_o[0])
  );

  cpuid_csr_window #(.ADDR_W(12), .CSR_BASE(BASE), .SETTLE_CYCLES(4)) dut1 (
    .clk(clk), .rst_n(rst_n_d[1]), .bus(bus1),
    .cpuid_leaf(leaf_o[1]), .cpuid_subleaf(sub_o[1]),
    .cpuid_data0(cd1[0]), .cpuid_data1(cd1[1]), .cpuid_data2(cd1[2]), .cpuid_data3(cd1[3]),
    .busy(busy_o[1])
  );

  // One bus transaction. Returns in the cycle after acceptance (+1ns) with
  // the response fields; 'waited' counts cycles req_ready was low.
  task automatic csr_op(input int d, input logic wr, input logic [11:0] addr,
                        input logic [63:0] wd, output logic [63:0] rd,
                        output logic er, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    req_valid_d[d] = 1'b1;
    req_write_d[d] = wr;
    req_addr_d[d]  = addr;
    req_wdata_d[d] = wd;
    while (!acc && waited < 100) begin
      @(negedge clk);
      if (req_ready_o[d]) acc = 1'b1;
      else waited++;
      @(posedge clk);
      #1;
    end
    req_valid_d[d] = 1'b0;
    if (rsp_valid_o[d]) begin
      rd = rsp_rdata_o[d];
      er = rsp_err_o[d];
    end else begin
      rd = 'x;
      er = 1'bx;
    end
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL accept_timeout dut%0d addr=%h got waited=%0d need accept", d, addr, waited);
    end
    $display("txn dut%0d %s addr=%h wdata=%h -> rdata=%h err=%b waited=%0d",
             d, wr ? "WR" : "RD", addr, wd, rd, er, waited);
  endtask

  task automatic test_reset();
    logic [63:0] rd; logic er; int w;
    rst_n_d[0] = 1'b0; rst_n_d[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n_d[0] = 1'b1; rst_n_d[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (busy_o[d] !== 1'b0 || req_ready_o[d] !== 1'b1 || rsp_valid_o[d] !== 1'b0 ||
          leaf_o[d] !== 32'h0 || sub_o[d] !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d got busy=%b ready=%b rspv=%b leaf=%h sub=%h need 0/1/0/0/0",
                 d, busy_o[d], req_ready_o[d], rsp_valid_o[d], leaf_o[d], sub_o[d]);
      end
    end
    for (int off = 0; off < 7; off++) begin
      csr_op(0, 1'b0, BASE + 12'(off), 64'h0, rd, er, w);
      total++;
      if (rd !== 64'h0 || er !== 1'b0) begin
        bad++;
        $display("FAIL reset_read off=%0d got rdata=%h err=%b need 0/0", off, rd, er);
      end
    end
  endtask

  task automatic test_vendor_query(input int d);
    logic [63:0] rd; logic er; int w; int cnt; int s;
    s = (d == 0) ? 1 : 4;
    csr_op(d, 1'b1, BASE, 64'h0000_0000_0000_1234, rd, er, w);
    total++;
    if (leaf_o[d] !== 32'h1234 || er !== 1'b0 || rd !== 64'h0) begin
      bad++;
      $display("FAIL leaf_write dut%0d got leaf=%h err=%b rdata=%h need 1234/0/0", d, leaf_o[d], er, rd);
    end
    csr_op(d, 1'b1, BASE, {32'hDEAD_BEEF, LEAF_VENDOR}, rd, er, w);
    csr_op(d, 1'b0, BASE, 64'h0, rd, er, w);
    total++;
    if (rd !== 64'h0 || leaf_o[d] !== LEAF_VENDOR) begin
      bad++;
      $display("FAIL leaf_upper_ignored dut%0d got rdata=%h leaf=%h need 0/0", d, rd, leaf_o[d]);
    end
    csr_op(d, 1'b1, BASE + 12'd2, 64'h1, rd, er, w);
    total++;
    if (er !== 1'b0 || rd !== 64'h0) begin
      bad++;
      $display("FAIL go_response dut%0d got err=%b rdata=%h need 0/0", d, er, rd);
    end
    cnt = 0;
    while (busy_o[d] === 1'b1 && cnt < 50) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    total++;
    if (cnt != s) begin
      bad++;
      $display("FAIL busy_length dut%0d got %0d need %0d", d, cnt, s);
    end
    csr_op(d, 1'b0, BASE + 12'd2, 64'h0, rd, er, w);
    total++;
    if (rd !== 64'h2) begin
      bad++;
      $display("FAIL status_done dut%0d got %h need 2", d, rd);
    end
    for (int k = 0; k < 4; k++) begin
      logic [63:0] exp;
      case (k)
        0: exp = 64'h0000_0000_0000_0010;
        1: exp = 64'h0000_0000_4252_4143;
        2: exp = 64'h0000_0000_5A2D_4E4F;
        default: exp = 64'h0000_0000_2030_3834;
      endcase
      csr_op(d, 1'b0, BASE + 12'd3 + 12'(k), 64'h0, rd, er, w);
      total++;
      if (rd !== exp || er !== 1'b0) begin
        bad++;
        $display("FAIL vendor_data%0d dut%0d got %h err=%b need %h", k, d, rd, er, exp);
      end
    end
  endtask

  task automatic test_read_while_busy(input int d);
    logic [63:0] rd; logic er; int w; int s;
    s = (d == 0) ? 1 : 4;
    csr_op(d, 1'b1, BASE, 64'h5, rd, er, w);
    csr_op(d, 1'b0, BASE + 12'd2, 64'h0, rd, er, w);
    total++;
    if (rd !== 64'h0) begin
      bad++;
      $display("FAIL leaf_write_clears_done dut%0d got status=%h need 0", d, rd);
    end
    csr_op(d, 1'b1, BASE + 12'd1, 64'h9, rd, er, w);
    csr_op(d, 1'b1, BASE + 12'd2, 64'h1, rd, er, w);
    csr_op(d, 1'b0, BASE + 12'd3, 64'h0, rd, er, w);
    total++;
    if (w != s) begin
      bad++;
      $display("FAIL ready_low_while_busy dut%0d got %0d cycles need %0d", d, w, s);
    end
    total++;
    if (rd !== {32'h5, 32'h9 ^ 32'h1} || er !== 1'b0) begin
      bad++;
      $display("FAIL read_new_capture dut%0d got %h err=%b need %h", d, rd, er, {32'h5, 32'h8});
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd; logic er; int w;
    rsp_ready_d[0] = 1'b0;
    csr_op(0, 1'b0, BASE, 64'h0, rd, er, w);
    total++;
    if (rd !== 64'h5) begin
      bad++;
      $display("FAIL stall_first_read got %h need 5", rd);
    end
    req_valid_d[0] = 1'b1; req_write_d[0] = 1'b0;
    req_addr_d[0]  = BASE + 12'd1; req_wdata_d[0] = 64'h0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rsp_valid_o[0] !== 1'b1 || rsp_rdata_o[0] !== 64'h5 || rsp_err_o[0] !== 1'b0 ||
          req_ready_o[0] !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got v=%b d=%h e=%b ready=%b need 1/5/0/0",
                 i, rsp_valid_o[0], rsp_rdata_o[0], rsp_err_o[0], req_ready_o[0]);
      end
      @(posedge clk);
      #1;
    end
    rsp_ready_d[0] = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready_o[0] !== 1'b1) begin
      bad++;
      $display("FAIL release_ready got %b need 1", req_ready_o[0]);
    end
    @(posedge clk);
    #1;
    req_valid_d[0] = 1'b0;
    total++;
    if (rsp_valid_o[0] !== 1'b1 || rsp_rdata_o[0] !== 64'h9) begin
      bad++;
      $display("FAIL same_cycle_accept got v=%b d=%h need 1/9", rsp_valid_o[0], rsp_rdata_o[0]);
    end
    $display("txn dut0 RD addr=%h -> rdata=%h (after release)", BASE + 12'd1, rsp_rdata_o[0]);
  endtask

  task automatic test_errors();
    logic [63:0] rd; logic er; int w; logic [63:0] exp2;
    exp2 = {32'h5 + 32'h0202_0000, 32'h9 ^ 32'h3};
    csr_op(0, 1'b1, BASE + 12'd5, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, w);
    total++;
    if (er !== 1'b1 || rd !== 64'h0) begin
      bad++;
      $display("FAIL write_data2 got err=%b rdata=%h need 1/0", er, rd);
    end
    csr_op(0, 1'b0, BASE + 12'd7, 64'h0, rd, er, w);
    total++;
    if (er !== 1'b1 || rd !== 64'h0) begin
      bad++;
      $display("FAIL read_off7 got err=%b rdata=%h need 1/0", er, rd);
    end
    csr_op(0, 1'b0, BASE + 12'd8, 64'h0, rd, er, w);
    total++;
    if (er !== 1'b1 || rd !== 64'h0) begin
      bad++;
      $display("FAIL read_out_of_window got err=%b rdata=%h need 1/0", er, rd);
    end
    csr_op(0, 1'b1, BASE + 12'd8, 64'h1, rd, er, w);
    total++;
    if (er !== 1'b1 || busy_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL write_out_of_window got err=%b busy=%b need 1/0", er, busy_o[0]);
    end
    csr_op(0, 1'b0, BASE + 12'd5, 64'h0, rd, er, w);
    total++;
    if (rd !== exp2 || er !== 1'b0) begin
      bad++;
      $display("FAIL data2_unchanged got %h err=%b need %h", rd, er, exp2);
    end
    csr_op(0, 1'b1, BASE + 12'd2, 64'h2, rd, er, w);
    total++;
    if (er !== 1'b0 || busy_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL ctrl_no_go got err=%b busy=%b need 0/0", er, busy_o[0]);
    end
    csr_op(0, 1'b0, BASE + 12'd2, 64'h0, rd, er, w);
    total++;
    if (rd !== 64'h2) begin
      bad++;
      $display("FAIL ctrl_no_go_status got %h need 2", rd);
    end
  endtask

  task automatic test_reset_mid_query();
    logic [63:0] rd; logic er; int w;
    csr_op(1, 1'b1, BASE, 64'h7, rd, er, w);
    csr_op(1, 1'b1, BASE + 12'd2, 64'h1, rd, er, w);
    @(posedge clk);
    #1;
    rst_n_d[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n_d[1] = 1'b1;
    total++;
    if (busy_o[1] !== 1'b0 || leaf_o[1] !== 32'h0 || req_ready_o[1] !== 1'b1) begin
      bad++;
      $display("FAIL abort_outputs got busy=%b leaf=%h ready=%b need 0/0/1",
               busy_o[1], leaf_o[1], req_ready_o[1]);
    end
    for (int off = 2; off < 7; off++) begin
      csr_op(1, 1'b0, BASE + 12'(off), 64'h0, rd, er, w);
      total++;
      if (rd !== 64'h0 || er !== 1'b0) begin
        bad++;
        $display("FAIL abort_clear off=%0d got %h err=%b need 0/0", off, rd, er);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n_d[d] = 1'b0; req_valid_d[d] = 1'b0; req_write_d[d] = 1'b0;
      req_addr_d[d] = '0; req_wdata_d[d] = '0; rsp_ready_d[d] = 1'b1;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_vendor_query(0);
    test_vendor_query(1);
    test_read_while_busy(0);
    test_read_while_busy(1);
    test_back_to_back();
    test_errors();
    test_reset_mid_query();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpuid_csr_window.md
Name: cpuid_csr_window

Overview:
- CSR-window transport front-end for the Z480 CPUID leaf model.
- Accepts CSR read/write requests on a valid/ready channel and holds the leaf/subleaf selector registers that drive the combinational CPUID block.
- On a software "go" it waits a settle interval, then captures the four 64-bit result lanes into readable DATA registers.
- Sits between the core CSR unit (upstream) and the CPUID leaf model (downstream).

Parameters:
- ADDR_W, 12, CSR address width.
- CSR_BASE, 12'h0C0, window base address; must be 8-aligned (low 3 bits zero).
- SETTLE_CYCLES, 1, cycles between go acceptance and capture; legal range 1..15.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  CSR request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  CSR address.
- req_wdata  in  64  write data.
- rsp_valid  out  1  response valid; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  64  read data; 0 for writes and errors.
- rsp_err  out  1  access error flag.
- cpuid_leaf  out  32  leaf selector to the CPUID block.
- cpuid_subleaf  out  32  subleaf selector to the CPUID block.
- cpuid_data0..cpuid_data3  in  64 each  result lanes from the CPUID block.
- busy  out  1  query in progress.

Behaviour:
- Reset (rst_n = 0 at a clock edge) clears everything to 0: all outputs except req_ready, plus LEAF, SUBLEAF, DATA0-3, done, the settle counter and the FSM. req_ready is 1 after reset. A reset mid-query aborts the query with no capture.
- Decode:
  - The window is hit when req_addr[ADDR_W-1:3] == CSR_BASE[ADDR_W-1:3]; the offset is req_addr[2:0].
  - 0 = LEAF (rw, bits 31:0; upper 32 ignored on write, read as 0).
  - 1 = SUBLEAF (rw, same rule).
  - 2 = CTRL/STATUS. Write bit0 = go; other bits ignored. Read = {62'b0, done, busy}.
  - 3..6 = DATA0..DATA3 (ro).
  - 7, out-of-window addresses, and writes to 3..6: rsp_err = 1, rsp_rdata = 0, no state change.
- Handshake:
  - req_ready = !busy && (!rsp_valid || rsp_ready). Back-to-back accepts are allowed when the response drains in the same cycle.
  - Response latency is 1: the request is accepted in cycle T and rsp_valid is high in T+1.
  - rsp_valid, rsp_rdata and rsp_err are stable while rsp_valid && !rsp_ready.
  - Read data is sampled at acceptance.
- FSM states: IDLE, SETTLE, CAPTURE.
  - IDLE: accepted CTRL write with bit0 = 1 → SETTLE. The counter loads SETTLE_CYCLES-1, done is cleared, and busy goes high from T+1.
  - SETTLE: decrement each cycle; at 0 → CAPTURE.
  - CAPTURE: one cycle. DATA0-3 load from cpuid_data0-3 at the end of this cycle, done sets to 1, busy drops, → IDLE.
  - Timing: go accepted in cycle T, busy high in T+1..T+SETTLE_CYCLES, DATA valid and done = 1 from T+SETTLE_CYCLES+1. SETTLE_CYCLES = 1 therefore skips SETTLE and goes straight to CAPTURE in T+1.
  - The go write itself gets a normal response (err = 0) in T+1.
- While busy, req_ready = 0. No accepts occur, so LEAF/SUBLEAF cannot change during a query.
- A LEAF or SUBLEAF write clears done. DATA retains the previous capture.
- A CTRL write with bit0 = 0 has no effect and gets err = 0.
- cpuid_leaf and cpuid_subleaf are direct register outputs. A write takes effect on these outputs at T+1.

Test Plan:
1. After reset, read offsets 0..6 → rdata 0, err 0, busy 0, req_ready 1.
2. Write LEAF = CARBON_CPUID_LEAF_VENDOR, write CTRL = 1, poll STATUS until 2'b10, read DATA1/DATA2/DATA3 → 64'h0000_0000_4252_4143 / ..._5A2D_4E4F / ..._2030_3834. busy is high exactly SETTLE_CYCLES cycles (check with SETTLE_CYCLES = 1 and 4).
3. Go accepted, then req_valid held high with a DATA0 read → req_ready stays 0 until the cycle after capture, and the read returns the new capture.
4. Hold rsp_ready = 0 for 3 cycles after a LEAF read → rsp_valid/rdata stable, req_ready = 0. Release → same-cycle accept of the next request.
5. Write DATA2, read offset 7, access CSR_BASE+8 → each gives err = 1, rdata 0, DATA2 unchanged.
6. Pulse rst_n low in the SETTLE cycle with SETTLE_CYCLES = 4 → next cycle busy 0, done 0, DATA all 0, cpuid_leaf 0.
